// File: rtl/led_animator.sv
// LED pattern generator: steps one of several patterns every TICK_DIV enabled cycles.
// Modes: 0 run, 1 ping-pong, 2 fill, 3 blink, 4 binary count, 5..7 off.
module led_animator #(
    parameter int N_LEDS   = 8,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    output logic [N_LEDS-1:0] led_out,
    output logic              step,
    output logic [2:0]        cur_mode
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [N_LEDS-1:0] LED_ONE  = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        M_RUN   = 3'd0,
        M_PING  = 3'd1,
        M_FILL  = 3'd2,
        M_BLINK = 3'd3,
        M_COUNT = 3'd4,
        M_OFF5  = 3'd5,
        M_OFF6  = 3'd6,
        M_OFF7  = 3'd7
    } mode_t;

    mode_t             r_mode, w_nxt_mode;
    logic [CW-1:0]     r_count, w_nxt_count;
    logic [N_LEDS-1:0] r_led, w_nxt_led;
    logic              r_dir_up, w_nxt_dir_up;
    logic              r_step, w_nxt_step;
    logic              w_mode_chg;
    logic              w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= M_RUN;
            r_count  <= '0;
            r_led    <= LED_ONE;
            r_dir_up <= 1'b1;
            r_step   <= 1'b0;
        end else begin
            r_mode   <= w_nxt_mode;
            r_count  <= w_nxt_count;
            r_led    <= w_nxt_led;
            r_dir_up <= w_nxt_dir_up;
            r_step   <= w_nxt_step;
        end
    end

    always_comb begin
        w_mode_chg   = (mode != r_mode);
        w_tick       = en && (r_count == CNT_LAST);
        w_nxt_mode   = r_mode;
        w_nxt_count  = r_count;
        w_nxt_led    = r_led;
        w_nxt_dir_up = r_dir_up;
        w_nxt_step   = 1'b0;

        if (w_mode_chg) begin
            // A mode change takes priority over any tick in the same cycle.
            w_nxt_mode   = mode_t'(mode);
            w_nxt_count  = '0;
            w_nxt_dir_up = 1'b1;
            case (mode_t'(mode))
                M_RUN, M_PING: w_nxt_led = LED_ONE;
                M_BLINK:       w_nxt_led = '1;
                default:       w_nxt_led = '0;
            endcase
        end else if (en) begin
            w_nxt_count = w_tick ? '0 : r_count + 1'b1;
            if (w_tick) begin
                w_nxt_step = 1'b1;
                case (r_mode)
                    M_RUN:   w_nxt_led = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
                    M_PING: begin
                        // Reverse on reaching an end so the endpoints are shown once per turn.
                        if (r_dir_up) begin
                            if (r_led[N_LEDS-1]) begin
                                w_nxt_led    = r_led >> 1;
                                w_nxt_dir_up = 1'b0;
                            end else begin
                                w_nxt_led = r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                w_nxt_led    = r_led << 1;
                                w_nxt_dir_up = 1'b1;
                            end else begin
                                w_nxt_led = r_led >> 1;
                            end
                        end
                    end
                    M_FILL:  w_nxt_led = (&r_led) ? '0 : {r_led[N_LEDS-2:0], 1'b1};
                    M_BLINK: w_nxt_led = ~r_led;
                    M_COUNT: w_nxt_led = r_led + 1'b1;
                    default: w_nxt_led = '0;
                endcase
            end
        end
    end

    assign led_out  = r_led;
    assign step     = r_step;
    assign cur_mode = r_mode;

endmodule

// File: tb/tb_led_animator.sv
// Directed, table-driven bench for led_animator (N_LEDS=8, TICK_DIV=4).
module tb_led_animator;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] led_out;
    logic       step;
    logic [2:0] cur_mode;

    int n_checks = 0;
    int n_errors = 0;

    led_animator #(.N_LEDS(8), .TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .led_out  (led_out),
        .step     (step),
        .cur_mode (cur_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        int         cycles;
        logic [7:0] exp_led;
        logic       exp_step;
        logic [2:0] exp_mode;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic [2:0] m, input int c,
                       input logic [7:0] l, input logic s, input logic [2:0] cm);
        vec_t v;
        v.en = e; v.mode = m; v.cycles = c;
        v.exp_led = l; v.exp_step = s; v.exp_mode = cm;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] l, input logic s, input logic [2:0] cm);
        n_checks++;
        if (led_out !== l || step !== s || cur_mode !== cm) begin
            n_errors++;
            $display("FAIL %s: got led=%02h step=%b mode=%0d, expected led=%02h step=%b mode=%0d",
                     name, led_out, step, cur_mode, l, s, cm);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fill_exp [9];
        logic [7:0] ping_exp [15];
        fill_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        ping_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // run: one step every 4 cycles, then freeze with en=0
        add(1, 0, 3,  8'h01, 0, 0);
        add(1, 0, 1,  8'h02, 1, 0);
        add(1, 0, 4,  8'h04, 1, 0);
        add(1, 0, 1,  8'h04, 0, 0);
        add(0, 0, 10, 8'h04, 0, 0);
        add(1, 0, 2,  8'h04, 0, 0);
        add(1, 0, 1,  8'h08, 1, 0);
        // mode 0 -> 3 at count 2
        add(1, 0, 2,  8'h08, 0, 0);
        add(1, 3, 1,  8'hFF, 0, 3);
        add(1, 3, 3,  8'hFF, 0, 3);
        add(1, 3, 1,  8'h00, 1, 3);
        add(1, 3, 4,  8'hFF, 1, 3);
        // fill
        add(1, 2, 1,  8'h00, 0, 2);
        for (int i = 0; i < 9; i++) add(1, 2, 4, fill_exp[i], 1, 2);
        // ping-pong
        add(1, 1, 1,  8'h01, 0, 1);
        for (int i = 0; i < 15; i++) add(1, 1, 4, ping_exp[i], 1, 1);
        // count: 254 ticks to FE, then FF and wrap to 00
        add(1, 4, 1,    8'h00, 0, 4);
        add(1, 4, 1016, 8'hFE, 1, 4);
        add(1, 4, 4,    8'hFF, 1, 4);
        add(1, 4, 4,    8'h00, 1, 4);
        // off modes still pulse step
        add(1, 6, 1,  8'h00, 0, 6);
        add(1, 6, 3,  8'h00, 0, 6);
        add(1, 6, 1,  8'h00, 1, 6);
        add(1, 6, 4,  8'h00, 1, 6);
        // mode change coincident with a tick suppresses the step
        add(1, 6, 3,  8'h00, 0, 6);
        add(1, 5, 1,  8'h00, 0, 5);
        add(1, 5, 3,  8'h00, 0, 5);
        add(1, 3, 1,  8'hFF, 0, 3);

        rst = 1'b1; en = 1'b0; mode = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 8'h01, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            en   = vq[i].en;
            mode = vq[i].mode;
            run(vq[i].cycles);
            check($sformatf("vec%0d", i), vq[i].exp_led, vq[i].exp_step, vq[i].exp_mode);
        end

        // asynchronous reset between edges, mode=2 pending at release
        #1 rst = 1'b1;
        #1 check("async_reset", 8'h01, 1'b0, 3'd0);
        mode = 3'd2; en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run(1);
        check("release_mode2", 8'h00, 1'b0, 3'd2);
        run(4);
        check("release_mode2_tick", 8'h01, 1'b1, 3'd2);

        // release with mode=0 counts from zero
        @(negedge clk);
        rst = 1'b1; mode = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        run(3);
        check("release_mode0_cnt", 8'h01, 1'b0, 3'd0);
        run(1);
        check("release_mode0_tick", 8'h02, 1'b1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
